// File: rtl/fetch_sequencer.sv
// fetch_sequencer: ROM program counter with start/stall/jump/branch/halt.
// Optional wrap trap on sequential overflow with FETCH_WRAP_TRAP_EN.
module fetch_sequencer #(
  parameter int D = 12,
  parameter int OFF_W = 8,
  parameter logic [D-1:0] START_ADDR = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             halt,
  input  logic             jump,
  input  logic [D-1:0]     target,
  input  logic             branch_taken,
  input  logic [OFF_W-1:0] offset,
  output logic [D-1:0]     prog_ctr,
  output logic             fetch_valid,
  output logic             busy,
  output logic             done
`ifdef FETCH_WRAP_TRAP_EN
  ,
  output logic             trap
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10,
    BAD  = 2'b11
  } state_t;

  localparam int EXT = D - OFF_W;
  localparam logic [D-1:0] ONE = {{(D-1){1'b0}}, 1'b1};

  state_t       state;
  state_t       state_n;
  logic [D-1:0] pc_n;
  logic [D-1:0] off_ext;

`ifdef FETCH_WRAP_TRAP_EN
  localparam logic [D-1:0] LAST = '1;
  logic trap_n;
`endif

  assign off_ext = {{EXT{offset[OFF_W-1]}}, offset};

  assign busy        = (state == RUN);
  assign done        = (state == DONE);
  assign fetch_valid = busy & ~stall;

  // State and PC registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      prog_ctr <= START_ADDR;
`ifdef FETCH_WRAP_TRAP_EN
      trap     <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      prog_ctr <= pc_n;
`ifdef FETCH_WRAP_TRAP_EN
      trap     <= trap_n;
`endif
    end
  end

  // Next state and next PC; RUN requests resolved in priority order.
  always_comb begin
    state_n = state;
    pc_n    = prog_ctr;
`ifdef FETCH_WRAP_TRAP_EN
    trap_n  = trap;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          pc_n    = START_ADDR;
`ifdef FETCH_WRAP_TRAP_EN
          trap_n  = 1'b0;
`endif
        end
      end
      RUN: begin
        if (!stall) begin
          if (halt) begin
            state_n = DONE;
          end else if (jump) begin
            pc_n = target;
          end else if (branch_taken) begin
            pc_n = prog_ctr + off_ext;
          end else begin
`ifdef FETCH_WRAP_TRAP_EN
            if (prog_ctr == LAST) begin
              state_n = DONE;
              trap_n  = 1'b1;
            end else begin
              pc_n = prog_ctr + ONE;
            end
`else
            pc_n = prog_ctr + ONE;
`endif
          end
        end
      end
      DONE: begin
        if (start) begin
          state_n = RUN;
          pc_n    = START_ADDR;
`ifdef FETCH_WRAP_TRAP_EN
          trap_n  = 1'b0;
`endif
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: table-driven directed bench for fetch_sequencer.
// Define FETCH_WRAP_TRAP_EN to exercise the trap build.
module tb_fetch_sequencer;

  localparam int D = 12;
  localparam int OFF_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             stall;
  logic             halt;
  logic             jump;
  logic [D-1:0]     target;
  logic             branch_taken;
  logic [OFF_W-1:0] offset;
  logic [D-1:0]     prog_ctr;
  logic             fetch_valid;
  logic             busy;
  logic             done;
  logic             trap_obs;

`ifdef FETCH_WRAP_TRAP_EN
  logic trap;
  assign trap_obs = trap;
`else
  assign trap_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  fetch_sequencer #(.D(D), .OFF_W(OFF_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stall        (stall),
    .halt         (halt),
    .jump         (jump),
    .target       (target),
    .branch_taken (branch_taken),
    .offset       (offset),
    .prog_ctr     (prog_ctr),
    .fetch_valid  (fetch_valid),
    .busy         (busy),
    .done         (done)
`ifdef FETCH_WRAP_TRAP_EN
    ,
    .trap         (trap)
`endif
  );

  typedef struct {
    logic         rst;
    logic         st;
    logic         stl;
    logic         hlt;
    logic         jmp;
    logic [11:0]  tgt;
    logic         br;
    logic [7:0]   off;
    logic         chk_fv;
    logic         fv;
    logic [11:0]  pc;
    logic         bsy;
    logic         dn;
    logic         trp;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic vec_t mk(
    logic rst, logic st, logic stl, logic hlt,
    logic jmp, logic [11:0] tgt, logic br, logic [7:0] off,
    logic chk_fv, logic fv,
    logic [11:0] pc, logic bsy, logic dn, logic trp);
    vec_t v;
    v.rst = rst; v.st = st; v.stl = stl; v.hlt = hlt;
    v.jmp = jmp; v.tgt = tgt; v.br = br; v.off = off;
    v.chk_fv = chk_fv; v.fv = fv;
    v.pc = pc; v.bsy = bsy; v.dn = dn; v.trp = trp;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    reset        = v.rst;
    start        = v.st;
    stall        = v.stl;
    halt         = v.hlt;
    jump         = v.jmp;
    target       = v.tgt;
    branch_taken = v.br;
    offset       = v.off;
  endtask

  task automatic apply(int i, vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    if (v.chk_fv)
      chk($sformatf("v%0d fetch_valid", i),
          32'(fetch_valid), 32'(v.fv));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d prog_ctr", i),
        32'(prog_ctr), 32'(v.pc));
    chk($sformatf("v%0d busy", i), 32'(busy), 32'(v.bsy));
    chk($sformatf("v%0d done", i), 32'(done), 32'(v.dn));
`ifdef FETCH_WRAP_TRAP_EN
    chk($sformatf("v%0d trap", i), 32'(trap_obs), 32'(v.trp));
`endif
  endtask

  initial begin
    vec_t idle_v;
    reset = 1'b1; start = 1'b0; stall = 1'b0; halt = 1'b0;
    jump = 1'b0; target = '0; branch_taken = 1'b0; offset = '0;

    // reset, idle ignores requests, start
    vecs.push_back(mk(1,0,0,0,0,12'h000,0,8'h00, 0,0, 12'h000,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,12'h000,0,8'h00, 1,0, 12'h000,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,12'h000,0,8'h00, 1,0, 12'h000,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,12'h055,1,8'h04, 1,0, 12'h000,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,12'h000,0,8'h00, 1,0, 12'h000,1,0,0));
    for (int p = 1; p <= 5; p++)
      vecs.push_back(mk(0,0,0,0,0,12'h000,0,8'h00, 1,1, 12'(p),1,0,0));
    // stall for 3 cycles, requests ignored
    vecs.push_back(mk(0,0,1,0,0,12'h000,0,8'h00, 1,0, 12'h005,1,0,0));
    vecs.push_back(mk(0,0,1,1,0,12'h000,0,8'h00, 1,0, 12'h005,1,0,0));
    vecs.push_back(mk(0,0,1,0,1,12'h300,1,8'h10, 1,0, 12'h005,1,0,0));
    for (int p = 6; p <= 10; p++)
      vecs.push_back(mk(0,0,0,0,0,12'h000,0,8'h00, 1,1, 12'(p),1,0,0));
    // jump beats branch, then negative branch
    vecs.push_back(mk(0,0,0,0,1,12'h0F0,1,8'h05, 1,1, 12'h0F0,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,12'h000,1,8'hFC, 1,1, 12'h0EC,1,0,0));
    // stall masks halt, then halt
    vecs.push_back(mk(0,0,1,1,0,12'h000,0,8'h00, 1,0, 12'h0EC,1,0,0));
    vecs.push_back(mk(0,0,0,1,0,12'h000,0,8'h00, 1,1, 12'h0EC,0,1,0));
    vecs.push_back(mk(0,0,0,0,0,12'h000,0,8'h00, 1,0, 12'h0EC,0,1,0));
    vecs.push_back(mk(0,0,0,0,1,12'h123,1,8'h04, 1,0, 12'h0EC,0,1,0));
    // restart from DONE; start held in RUN ignored
    vecs.push_back(mk(0,1,0,0,0,12'h000,0,8'h00, 1,0, 12'h000,1,0,0));
    vecs.push_back(mk(0,1,0,0,0,12'h000,0,8'h00, 1,1, 12'h001,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,12'h000,0,8'h00, 1,1, 12'h002,1,0,0));
    // branch wraps below zero
    vecs.push_back(mk(0,0,0,0,0,12'h000,1,8'hFD, 1,1, 12'hFFF,1,0,0));
`ifdef FETCH_WRAP_TRAP_EN
    vecs.push_back(mk(0,0,0,0,0,12'h000,0,8'h00, 1,1, 12'hFFF,0,1,1));
    vecs.push_back(mk(0,1,0,0,0,12'h000,0,8'h00, 1,0, 12'h000,1,0,0));
`else
    vecs.push_back(mk(0,0,0,0,0,12'h000,0,8'h00, 1,1, 12'h000,1,0,0));
    vecs.push_back(mk(0,1,0,0,0,12'h000,0,8'h00, 1,1, 12'h001,1,0,0));
`endif
    // mid-run reset beats jump and start
    vecs.push_back(mk(0,0,0,0,1,12'h007,0,8'h00, 1,1, 12'h007,1,0,0));
    vecs.push_back(mk(1,1,0,0,1,12'h200,0,8'h00, 1,1, 12'h000,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,12'h000,0,8'h00, 1,0, 12'h000,1,0,0));
    // jump to top, then sequential step
    vecs.push_back(mk(0,0,0,0,1,12'hFFF,0,8'h00, 1,1, 12'hFFF,1,0,0));
`ifdef FETCH_WRAP_TRAP_EN
    vecs.push_back(mk(0,0,0,0,0,12'h000,0,8'h00, 1,1, 12'hFFF,0,1,1));
    vecs.push_back(mk(0,1,0,0,0,12'h000,0,8'h00, 1,0, 12'h000,1,0,0));
`else
    vecs.push_back(mk(0,0,0,0,0,12'h000,0,8'h00, 1,1, 12'h000,1,0,0));
    vecs.push_back(mk(0,1,0,0,0,12'h000,0,8'h00, 1,1, 12'h001,1,0,0));
`endif
    // branch wrap over the top never traps
    vecs.push_back(mk(0,0,0,0,1,12'hFFE,0,8'h00, 1,1, 12'hFFE,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,12'h000,1,8'h03, 1,1, 12'h001,1,0,0));
    vecs.push_back(mk(1,0,0,0,0,12'h000,0,8'h00, 1,1, 12'h000,0,0,0));

    foreach (vecs[i]) apply(i, vecs[i]);

    // start held high from IDLE: one restart, then counting
    idle_v = mk(0,1,0,0,0,12'h000,0,8'h00, 0,0, 12'h000,0,0,0);
    @(negedge clk);
    drive(idle_v);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold_start pc%0d", k),
          32'(prog_ctr), 32'(k));
      chk($sformatf("hold_start busy%0d", k), 32'(busy), 32'd1);
    end
    @(negedge clk);
    start = 1'b0;
    stall = 1'b1;
    #1;
    chk("hold_start stall fv", 32'(fetch_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("hold_start stall pc", 32'(prog_ctr), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Program-counter controller that sequences the 9-bit-wide instruction ROM. It drives the ROM address `prog_ctr` and supports:
- run start from an idle state,
- sequential fetch, stall, absolute jump, PC-relative branch,
- halt with a done handshake back to the testbench/top level.

It sits between the top-level start/done interface and the decoder/ALU branch outputs, and feeds `prog_ctr` to the ROM every cycle.

Parameters:
- D, 12, ROM address width; `prog_ctr` width, ROM depth 2**D.
- OFF_W, 8, width of the signed relative branch offset.
- START_ADDR, 0, PC value loaded on reset and on every accepted start.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE or DONE.
- stall  input  1  hold PC this cycle (datapath not ready).
- halt  input  1  decoded halt instruction at current PC.
- jump  input  1  absolute jump request.
- target  input  D  absolute jump address.
- branch_taken  input  1  relative branch request (condition already resolved).
- offset  input  OFF_W  signed two's-complement branch offset.
- prog_ctr  output  D  ROM address, registered.
- fetch_valid  output  1  `mach_code` at `prog_ctr` is being consumed this cycle.
- busy  output  1  high in RUN.
- done  output  1  high in DONE, level until next start or reset.
- trap  output  1  only with FETCH_WRAP_TRAP_EN; wrap-around error flag.

Behaviour:
- States: IDLE=2'b00, RUN=2'b01, DONE=2'b10. The unused encoding 2'b11 goes to IDLE on the next edge.
- Reset (sync, any state, including mid-run): next edge gives state=IDLE, prog_ctr=START_ADDR, busy=0, done=0, fetch_valid=0, trap=0. Reset has priority over every other input.
- Outputs are decoded from state only (Moore), except fetch_valid:
  - busy = (state==RUN).
  - done = (state==DONE).
  - fetch_valid = (state==RUN) & ~stall.
- IDLE:
  - start=1 → RUN, prog_ctr=START_ADDR.
  - Otherwise hold. All request inputs are ignored.
- RUN: one update per edge, in this fixed priority:
  1. stall=1: prog_ctr holds; halt/jump/branch ignored this cycle.
  2. halt=1: state → DONE; prog_ctr holds (points at the halt instruction).
  3. jump=1: prog_ctr = target.
  4. branch_taken=1: prog_ctr = prog_ctr + sign_extend(offset) modulo 2**D.
  5. Otherwise: prog_ctr = prog_ctr + 1 modulo 2**D.
- start is ignored in RUN.
- jump and branch_taken both high: jump wins.
- Arithmetic: offset is sign-extended to D bits, the sum is truncated to D bits, and wrap occurs silently in both directions (without the macro).
- Latency: a new prog_ctr is visible on the cycle after the request edge. The ROM is combinational, so mach_code follows in the same cycle.
- DONE:
  - done held high; prog_ctr frozen.
  - start=1 → RUN with prog_ctr=START_ADDR; done drops on that same edge.
- start held high across DONE→RUN does not restart a run again while in RUN.

Optional Feature:
Macro FETCH_WRAP_TRAP_EN.
- Defined:
  - Port trap exists.
  - In RUN, when a sequential increment (priority 5) with prog_ctr == 2**D-1 occurs: state → DONE, prog_ctr holds at 2**D-1, trap=1.
  - trap clears on reset or on an accepted start.
  - Wrap from jump or branch does not trap.
- Undefined:
  - No trap port and no trap logic.
  - Sequential increment wraps 2**D-1 → 0.

Test Plan:
- reset=1 for 2 cycles, then start pulse → prog_ctr 0,1,2,3 on successive cycles; busy=1, fetch_valid=1, done=0.
- At PC=5: stall=1 for 3 cycles, then release → PC stays 5 for 3 cycles with fetch_valid=0, then 6.
- At PC=10: jump=1, target=12'h0F0, branch_taken=1 simultaneously → PC=0x0F0. Next cycle branch_taken=1, offset=8'hFC → PC=0x0EC.
- At PC=0x0EC: halt=1 and stall=1 together → PC holds, still RUN. Next cycle halt=1 alone → DONE, done=1, busy=0, PC=0x0EC. Then start → PC=0, done=0.
- Mid-run at PC=7: assert reset for 1 cycle → IDLE, PC=0, busy=0. Also a branch from PC=2 with offset=8'hFD → PC=0xFFF (wrap).
- Jump to 0xFFF, then one sequential step:
  - without the macro → PC=0x000, still RUN;
  - with FETCH_WRAP_TRAP_EN → DONE, trap=1, PC=0xFFF; a subsequent start clears trap.
